settle_monitor: RTL

- Downstream consumer of the msdsl filter's fixed-point real output (v_out); sits between the filter and the emulator's result/readback logic.
- After a start pulse, counts valid samples and decides when v_out has settled: within ±tol of a target for HOLD consecutive samples.
- Reports the settling sample index, or a timeout. Gives on-chip step-response checks without streaming every sample off the FPGA.

---
 rtl/settle_monitor_pkg.sv | 17 +
 rtl/settle_monitor_band_check.sv | 14 +
 rtl/settle_monitor.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/settle_monitor_pkg.sv
// settle_monitor_pkg: shared state encoding, default parameters and magnitude helper
package settle_monitor_pkg;
    localparam int DEF_WIDTH       = 18;
    localparam int DEF_HOLD        = 16;
    localparam int DEF_CNT_W       = 24;
    localparam int DEF_MAX_SAMPLES = 1000000;

    typedef enum logic [1:0] {IDLE, TRACK, SETTLED, TIMEOUT} state_t;

    // Callers sign-extend their operands to 64 bits, so the difference never
    // wraps for any word width up to 62 bits.
    function automatic logic [63:0] abs_diff(input logic signed [63:0] a, input logic signed [63:0] b);
        logic signed [63:0] d;
        d = a - b;
        return d < 0 ? -d : d;
    endfunction
endpackage

// File: rtl/settle_monitor_band_check.sv
// band_check: combinational |i_v_in - i_target| <= i_tol window comparator
//   i_v_in, i_target : signed words sharing one exponent
//   i_tol            : unsigned band half-width, same exponent
//   o_in_band        : high when the sample lies inside the band (edge inclusive)
module band_check import settle_monitor_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic signed [WIDTH-1:0] i_v_in,
    input  logic signed [WIDTH-1:0] i_target,
    input  logic        [WIDTH-2:0] i_tol,
    output logic                    o_in_band
);
    assign o_in_band = abs_diff(64'(i_v_in), 64'(i_target)) <= 64'(i_tol);
endmodule

// File: rtl/settle_monitor.sv
// settle_monitor: measures when a fixed-point filter output settles within +/-tol of a target
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : one-cycle pulse arming (or restarting) a measurement
//   v_valid, v_in         : sample strobe and signed sample
//   target, tol           : expected final value and unsigned band half-width
//   busy                  : measurement in progress
//   done                  : one-cycle pulse when the measurement ends
//   settled, timeout      : sticky outcome flags
//   settle_time           : index of the first sample of the qualifying run (MAX_SAMPLES on timeout)
//   peak                  : max sample seen while tracking, only with SETTLE_MONITOR_PEAK_EN defined
module settle_monitor import settle_monitor_pkg::*; #(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HOLD        = DEF_HOLD,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int MAX_SAMPLES = DEF_MAX_SAMPLES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    v_valid,
    input  logic signed [WIDTH-1:0] v_in,
    input  logic signed [WIDTH-1:0] target,
    input  logic        [WIDTH-2:0] tol,
    output logic                    busy,
    output logic                    done,
    output logic                    settled,
    output logic                    timeout,
    output logic        [CNT_W-1:0] settle_time
`ifdef SETTLE_MONITOR_PEAK_EN
    ,
    output logic signed [WIDTH-1:0] peak
`endif
);
    localparam int RUN_W = $clog2(HOLD + 1);
    localparam logic [CNT_W-1:0] MAX_N    = CNT_W'(MAX_SAMPLES);
    localparam logic [RUN_W-1:0] LAST_RUN = RUN_W'(HOLD - 1);

    state_t             r_state, w_state;
    logic [CNT_W-1:0]   r_n, w_n;
    logic [RUN_W-1:0]   r_run, w_run;
    logic [CNT_W-1:0]   r_cand, w_cand;
    logic [CNT_W-1:0]   r_settle_time, w_settle_time;
    logic               r_busy, r_done, w_done;
    logic               r_settled, w_settled;
    logic               r_timeout, w_timeout;
    logic               w_in_band;
`ifdef SETTLE_MONITOR_PEAK_EN
    logic signed [WIDTH-1:0] r_peak, w_peak;
`endif

    band_check #(.WIDTH(WIDTH)) u_band (
        .i_v_in   (v_in),
        .i_target (target),
        .i_tol    (tol),
        .o_in_band(w_in_band)
    );

    always_comb begin
        w_state       = r_state;
        w_n           = r_n;
        w_run         = r_run;
        w_cand        = r_cand;
        w_settle_time = r_settle_time;
        w_settled     = r_settled;
        w_timeout     = r_timeout;
        w_done        = 1'b0;
`ifdef SETTLE_MONITOR_PEAK_EN
        w_peak        = r_peak;
`endif
        // start outranks a coincident sample, which is therefore dropped
        if (start) begin
            w_state       = TRACK;
            w_n           = '0;
            w_run         = '0;
            w_cand        = '0;
            w_settle_time = '0;
            w_settled     = 1'b0;
            w_timeout     = 1'b0;
`ifdef SETTLE_MONITOR_PEAK_EN
            w_peak        = '0;
`endif
        end else if (r_state == TRACK && v_valid) begin
            w_run  = w_in_band ? r_run + 1'b1 : '0;
            w_cand = (w_in_band && r_run == '0) ? r_n : r_cand;
            w_n    = (r_n == MAX_N) ? r_n : r_n + 1'b1;
`ifdef SETTLE_MONITOR_PEAK_EN
            w_peak = (r_n == '0 || v_in > r_peak) ? v_in : r_peak;
`endif
            // settling is tested first so it wins a tie with the timeout
            if (w_in_band && r_run == LAST_RUN) begin
                w_state       = SETTLED;
                w_settled     = 1'b1;
                w_settle_time = w_cand;
                w_done        = 1'b1;
            end else if (w_n == MAX_N) begin
                w_state       = TIMEOUT;
                w_timeout     = 1'b1;
                w_settle_time = MAX_N;
                w_done        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_n           <= '0;
            r_run         <= '0;
            r_cand        <= '0;
            r_settle_time <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_settled     <= 1'b0;
            r_timeout     <= 1'b0;
`ifdef SETTLE_MONITOR_PEAK_EN
            r_peak        <= '0;
`endif
        end else begin
            r_state       <= w_state;
            r_n           <= w_n;
            r_run         <= w_run;
            r_cand        <= w_cand;
            r_settle_time <= w_settle_time;
            r_busy        <= (w_state == TRACK);
            r_done        <= w_done;
            r_settled     <= w_settled;
            r_timeout     <= w_timeout;
`ifdef SETTLE_MONITOR_PEAK_EN
            r_peak        <= w_peak;
`endif
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign settled     = r_settled;
    assign timeout     = r_timeout;
    assign settle_time = r_settle_time;
`ifdef SETTLE_MONITOR_PEAK_EN
    assign peak        = r_peak;
`endif
endmodule
